// File: rtl/decode_stage_if.sv
// Fetch/write-back inputs and decoded outputs of the ID stage.
// Signal names match the stage's external bus names.
interface decode_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instruction;
  logic            flush;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;

  modport master (
    output if_pc, if_instruction, flush,
    output ex_mem_read, ex_rd,
    output wb_reg_write, wb_rd, wb_data,
    input  stall, id_valid, id_pc,
    input  id_opcode, id_funct3, id_funct7_5,
    input  id_rs1, id_rs2, id_rd,
    input  id_rs1_data, id_rs2_data, id_imm
  );

  modport slave (
    input  if_pc, if_instruction, flush,
    input  ex_mem_read, ex_rd,
    input  wb_reg_write, wb_rd, wb_data,
    output stall, id_valid, id_pc,
    output id_opcode, id_funct3, id_funct7_5,
    output id_rs1, id_rs2, id_rd,
    output id_rs1_data, id_rs2_data, id_imm
  );
endinterface

// File: rtl/decode_stage.sv
// RV64I decode: IF/ID register, bypassed register file,
// immediate generator and load-use hazard detection.
module decode_stage #(
  parameter int unsigned XLEN = 64,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] rf_q [32];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       rs1_use, rs2_use;
  logic       stall;
  logic       wr_en;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data, rs2_data;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  assign rs1_use = opcode inside {
    7'h33, 7'h13, 7'h03, 7'h23,
    7'h63, 7'h67, 7'h1b, 7'h3b
  };
  assign rs2_use = opcode inside {
    7'h33, 7'h23, 7'h63, 7'h3b
  };

  assign stall = valid_q & bus.ex_mem_read
               & (bus.ex_rd != 5'd0)
               & ((rs1_use & (bus.ex_rd == rs1))
                | (rs2_use & (bus.ex_rd == rs2)));

  assign wr_en = bus.wb_reg_write & (bus.wb_rd != 5'd0);

  // Same-cycle write-back wins over the stored value
  assign rs1_data =
    (rs1 == 5'd0)                ? '0 :
    (wr_en && bus.wb_rd == rs1) ? bus.wb_data :
                                  rf_q[rs1];
  assign rs2_data =
    (rs2 == 5'd0)                ? '0 :
    (wr_en && bus.wb_rd == rs2) ? bus.wb_data :
                                  rf_q[rs2];

  always_comb begin
    imm = '0;
    case (opcode)
      7'h13, 7'h03, 7'h67, 7'h1b:
        imm = {{(XLEN-12){instr_q[31]}},
               instr_q[31:20]};
      7'h23:
        imm = {{(XLEN-12){instr_q[31]}},
               instr_q[31:25], instr_q[11:7]};
      7'h63:
        imm = {{(XLEN-13){instr_q[31]}},
               instr_q[31], instr_q[7],
               instr_q[30:25], instr_q[11:8], 1'b0};
      7'h37, 7'h17:
        imm = {{(XLEN-32){instr_q[31]}},
               instr_q[31:12], 12'b0};
      7'h6f:
        imm = {{(XLEN-21){instr_q[31]}},
               instr_q[31], instr_q[19:12],
               instr_q[20], instr_q[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Flush outranks a concurrent stall
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bus.flush) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = bus.if_pc;
      instr_d = bus.if_instruction;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      if (wr_en) begin
        rf_q[bus.wb_rd] <= bus.wb_data;
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.id_valid    = valid_q & ~stall;
  assign bus.id_pc       = pc_q;
  assign bus.id_opcode   = opcode;
  assign bus.id_funct3   = instr_q[14:12];
  assign bus.id_funct7_5 = instr_q[30];
  assign bus.id_rs1      = rs1;
  assign bus.id_rs2      = rs2;
  assign bus.id_rd       = rd;
  assign bus.id_rs1_data = rs1_data;
  assign bus.id_rs2_data = rs2_data;
  assign bus.id_imm      = imm;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed plan
// plus randomized traffic against a reference model.
module tb_decode_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0020_81B3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(64)) bus();

  decode_stage dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        v;
    logic        st;
    logic [63:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] imm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [63:0] m_pc;
  logic [31:0] m_ins;
  logic        m_v;
  logic [63:0] m_rf [32];

  logic        c_rst = 1'b1, c_fl = 1'b0;
  logic        c_mr = 1'b0, c_we = 1'b0;
  logic [4:0]  c_erd = '0, c_wrd = '0;
  logic [63:0] c_pc = '0, c_wd = '0;
  logic [31:0] c_ins = NOP;

  logic [6:0] ops [12] = '{
    7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67,
    7'h1b, 7'h3b, 7'h37, 7'h17, 7'h6f, 7'h0f
  };

  task automatic cmp(string n, logic [63:0] a,
                     logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  function automatic logic [63:0] sx(
    longint unsigned v, int bits);
    longint unsigned half;
    half = 64'd1 << (bits - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic logic [63:0] imm_of(logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h1b:
        return sx(64'(i[31:20]), 12);
      7'h23:
        return sx(64'(i[31:25]) * 32 + 64'(i[11:7]), 12);
      7'h63:
        return sx(64'(i[31]) * 4096 + 64'(i[7]) * 2048
                + 64'(i[30:25]) * 32 + 64'(i[11:8]) * 2, 13);
      7'h37, 7'h17:
        return sx(64'(i[31:12]) * 4096, 32);
      7'h6f:
        return sx(64'(i[31]) * 1048576
                + 64'(i[19:12]) * 4096
                + 64'(i[20]) * 2048
                + 64'(i[30:21]) * 2, 21);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic reads1(logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23,
                      7'h63, 7'h67, 7'h1b, 7'h3b};
  endfunction

  function automatic logic reads2(logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63, 7'h3b};
  endfunction

  function automatic logic m_stall();
    logic h1, h2;
    h1 = reads1(m_ins[6:0]) && c_erd == m_ins[19:15];
    h2 = reads2(m_ins[6:0]) && c_erd == m_ins[24:20];
    return m_v && c_mr && c_erd != 0 && (h1 || h2);
  endfunction

  function automatic logic [63:0] m_read(logic [4:0] a);
    if (a == 0) return 64'd0;
    if (c_we && c_wrd == a) return c_wd;
    return m_rf[a];
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    e.st  = m_stall();
    e.v   = m_v && !e.st;
    e.pc  = m_pc;
    e.op  = m_ins[6:0];
    e.f3  = m_ins[14:12];
    e.f7  = m_ins[30];
    e.rd  = m_ins[11:7];
    e.rs1 = m_ins[19:15];
    e.rs2 = m_ins[24:20];
    e.d1  = m_read(m_ins[19:15]);
    e.d2  = m_read(m_ins[24:20]);
    e.imm = imm_of(m_ins);
    return e;
  endfunction

  task automatic m_edge();
    logic st;
    st = m_stall();
    if (c_rst) begin
      m_pc = 0;
      m_ins = NOP;
      m_v = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (c_we && c_wrd != 0) m_rf[c_wrd] = c_wd;
      if (c_fl) begin
        m_ins = NOP;
        m_v = 0;
      end else if (!st) begin
        m_pc = c_pc;
        m_ins = c_ins;
        m_v = 1;
      end
    end
  endtask

  task automatic drive();
    reset              = c_rst;
    bus.flush          = c_fl;
    bus.if_pc          = c_pc;
    bus.if_instruction = c_ins;
    bus.ex_mem_read    = c_mr;
    bus.ex_rd          = c_erd;
    bus.wb_reg_write   = c_we;
    bus.wb_rd          = c_wrd;
    bus.wb_data        = c_wd;
  endtask

  task automatic step(
    input logic rst, input logic fl,
    input logic [63:0] pc, input logic [31:0] ins,
    input logic mr, input logic [4:0] erd,
    input logic we, input logic [4:0] wrd,
    input logic [63:0] wd);
    @(posedge clk);
    m_edge();
    #1;
    c_rst = rst; c_fl = fl; c_pc = pc; c_ins = ins;
    c_mr = mr; c_erd = erd;
    c_we = we; c_wrd = wrd; c_wd = wd;
    drive();
    sb.push_back(m_expect());
  endtask

  task automatic chk_reset_outputs();
    cmp("rst_valid", 64'(bus.id_valid), 0);
    cmp("rst_pc", bus.id_pc, 0);
    cmp("rst_opcode", 64'(bus.id_opcode), 64'h13);
    cmp("rst_rd", 64'(bus.id_rd), 0);
    cmp("rst_rs1", 64'(bus.id_rs1), 0);
    cmp("rst_rs2", 64'(bus.id_rs2), 0);
    cmp("rst_imm", bus.id_imm, 0);
    cmp("rst_rs1_data", bus.id_rs1_data, 0);
    cmp("rst_rs2_data", bus.id_rs2_data, 0);
    cmp("rst_stall", 64'(bus.stall), 0);
  endtask

  // Monitor: compare whatever the DUT presents each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("sb_valid", 64'(bus.id_valid), 64'(e.v));
        cmp("sb_stall", 64'(bus.stall), 64'(e.st));
        cmp("sb_pc", bus.id_pc, e.pc);
        cmp("sb_opcode", 64'(bus.id_opcode), 64'(e.op));
        cmp("sb_funct3", 64'(bus.id_funct3), 64'(e.f3));
        cmp("sb_funct7_5", 64'(bus.id_funct7_5), 64'(e.f7));
        cmp("sb_rd", 64'(bus.id_rd), 64'(e.rd));
        cmp("sb_rs1", 64'(bus.id_rs1), 64'(e.rs1));
        cmp("sb_rs2", 64'(bus.id_rs2), 64'(e.rs2));
        cmp("sb_rs1_data", bus.id_rs1_data, e.d1);
        cmp("sb_rs2_data", bus.id_rs2_data, e.d2);
        cmp("sb_imm", bus.id_imm, e.imm);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    drive();

    step(1, 0, 0, NOP, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_reset_outputs();

    step(0, 0, 0, 32'h0050_0093, 0, 0, 0, 0, 0);
    step(0, 0, 4, ADD, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t1_valid", 64'(bus.id_valid), 1);
    cmp("t1_opcode", 64'(bus.id_opcode), 64'h13);
    cmp("t1_rd", 64'(bus.id_rd), 1);
    cmp("t1_rs1", 64'(bus.id_rs1), 0);
    cmp("t1_imm", bus.id_imm, 5);
    cmp("t1_rs1_data", bus.id_rs1_data, 0);

    step(0, 0, 4, ADD, 0, 0, 1, 1, 64'hDEAD_BEEF);
    @(negedge clk);
    cmp("t2_bypass", bus.id_rs1_data, 64'hDEAD_BEEF);
    step(0, 0, 8, 32'h0050_0093, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t2_stored", bus.id_rs1_data, 64'hDEAD_BEEF);
    step(0, 0, 12, ADD, 0, 0, 1, 0, 64'h55);
    @(negedge clk);
    cmp("t2_x0", bus.id_rs1_data, 0);

    step(0, 0, 16, 32'h0011_0093, 1, 2, 0, 0, 0);
    @(negedge clk);
    cmp("t3_stall", 64'(bus.stall), 1);
    cmp("t3_valid_bubble", 64'(bus.id_valid), 0);
    step(0, 0, 16, 32'h0011_0093, 1, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t3_rd0_nostall", 64'(bus.stall), 0);
    cmp("t3_held_valid", 64'(bus.id_valid), 1);
    cmp("t3_held_pc", bus.id_pc, 12);
    cmp("t3_held_op", 64'(bus.id_opcode), 64'h33);
    step(0, 0, 20, ADD, 1, 1, 0, 0, 0);
    @(negedge clk);
    cmp("t3_itype_rs2", 64'(bus.stall), 0);
    cmp("t3_itype_valid", 64'(bus.id_valid), 1);

    step(0, 1, 24, 32'h0050_0093, 1, 2, 0, 0, 0);
    @(negedge clk);
    cmp("t4_pre_stall", 64'(bus.stall), 1);
    step(0, 0, 24, 32'hFE00_0EE3, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t4_opcode", 64'(bus.id_opcode), 64'h13);
    cmp("t4_rd", 64'(bus.id_rd), 0);
    cmp("t4_valid", 64'(bus.id_valid), 0);

    step(0, 0, 28, 32'h1234_50B7, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t5_beq_imm", bus.id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 32, 32'hFE11_2C23, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t5_lui_imm", bus.id_imm, 64'h0000_0000_1234_5000);
    step(0, 0, 36, 32'h0002_8093, 0, 0, 1, 5, 7);
    @(negedge clk);
    cmp("t5_sw_imm", bus.id_imm, 64'hFFFF_FFFF_FFFF_FFF8);

    step(0, 0, 40, NOP, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t6_x5_before", bus.id_rs1_data, 7);
    step(1, 0, 44, 32'h0002_8093, 1, 5, 0, 0, 0);
    step(0, 0, 44, 32'h0002_8093, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_reset_outputs();
    step(0, 0, 48, NOP, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("t6_x5_cleared", bus.id_rs1_data, 0);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(0, 11)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) == 0,
           {$urandom(), $urandom()}, ins,
           $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           {$urandom(), $urandom()});
    end

    repeat (2) @(negedge clk);
    cmp("sb_drained", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
